pipeline_reg_stage: RTL and testbench

//  Parametrised execute/writeback pipeline register chain for the RISC-V core.
//  - Carries the destination select, write enable and result through DEPTH register stages.
//  - Adds per-stage valid, stall (hold), flush (bubble) and x0 write suppression.
//  - Feeds the register-file write port; optionally supplies forwarding data to the decode/execute hazard logic.

---
 rtl/pipeline_reg_stage_if.sv | 54 +++++
 rtl/pipeline_reg_stage.sv | 91 +++++++++
 tb/tb_pipeline_reg_stage.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/pipeline_reg_stage_if.sv
// pipeline_reg_stage_if: execute/writeback pipeline bus.
//   Carries the control inputs (stall/flush), the incoming instruction
//   {valid, write enable, rd, result} and the last-stage outputs that feed
//   the register-file write port.
//   Optional macro PIPE_FWD_EN adds the forwarding compare signals
//   (rs1/rs2 selects in, hit/data out).
//   master modport: upstream/driver side; slave modport: the pipeline stage.
interface pipeline_reg_stage_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RD_W   = 6
);
  logic              stall_in;
  logic              flush_in;
  logic              valid_in;
  logic              write_enable_in;
  logic [RD_W-1:0]   rd_sel_in;
  logic [DATA_W-1:0] alu_result_in;
  logic              valid_out;
  logic              write_enable_out;
  logic [RD_W-1:0]   rd_sel_out;
  logic [DATA_W-1:0] alu_result_out;
`ifdef PIPE_FWD_EN
  logic [RD_W-1:0]   rs1_sel_in;
  logic [RD_W-1:0]   rs2_sel_in;
  logic              fwd_rs1_hit;
  logic              fwd_rs2_hit;
  logic [DATA_W-1:0] fwd_rs1_data;
  logic [DATA_W-1:0] fwd_rs2_data;

  modport master (
    output stall_in, flush_in, valid_in, write_enable_in, rd_sel_in, alu_result_in,
    output rs1_sel_in, rs2_sel_in,
    input  valid_out, write_enable_out, rd_sel_out, alu_result_out,
    input  fwd_rs1_hit, fwd_rs2_hit, fwd_rs1_data, fwd_rs2_data
  );

  modport slave (
    input  stall_in, flush_in, valid_in, write_enable_in, rd_sel_in, alu_result_in,
    input  rs1_sel_in, rs2_sel_in,
    output valid_out, write_enable_out, rd_sel_out, alu_result_out,
    output fwd_rs1_hit, fwd_rs2_hit, fwd_rs1_data, fwd_rs2_data
  );
`else
  modport master (
    output stall_in, flush_in, valid_in, write_enable_in, rd_sel_in, alu_result_in,
    input  valid_out, write_enable_out, rd_sel_out, alu_result_out
  );

  modport slave (
    input  stall_in, flush_in, valid_in, write_enable_in, rd_sel_in, alu_result_in,
    output valid_out, write_enable_out, rd_sel_out, alu_result_out
  );
`endif
endinterface

// File: rtl/pipeline_reg_stage.sv
// pipeline_reg_stage: DEPTH-stage execute/writeback register chain.
//   Each stage holds {valid, write enable, rd, result}. Stage 0 captures the
//   incoming instruction, stage DEPTH-1 drives the register-file write port.
//   Supports stall (hold all), flush (invalidate all, priority over stall)
//   and squashes writes to x0 at entry.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous reset, active-high (overrides stall and flush)
//   bus  - pipeline_reg_stage_if.slave (inputs, last-stage outputs,
//          optional forwarding compare)
// Optional macro PIPE_FWD_EN: adds combinational forwarding lookup for
//   rs1/rs2 across all stages (youngest match wins, data=0 on miss).
module pipeline_reg_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RD_W   = 6,
  parameter int unsigned DEPTH  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  pipeline_reg_stage_if.slave  bus
);

  localparam int unsigned LAST = DEPTH - 1;

  if (DEPTH < 1 || DEPTH > 8) begin : g_bad_depth
    $error("pipeline_reg_stage: DEPTH must be in 1..8");
  end

  logic [DEPTH-1:0]  v_q;
  logic [DEPTH-1:0]  we_q;
  logic [RD_W-1:0]   rd_q  [DEPTH];
  logic [DATA_W-1:0] res_q [DEPTH];

  // x0 writes are squashed at entry; valid/rd/result still travel down the pipe
  logic entry_we_c;
  assign entry_we_c = bus.valid_in & bus.write_enable_in & (bus.rd_sel_in != RD_W'(0));

  // Stage chain: reset > flush > stall > advance
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q  <= '0;
      we_q <= '0;
      for (int k = 0; k < int'(DEPTH); k++) begin
        rd_q[k]  <= '0;
        res_q[k] <= '0;
      end
    end else if (bus.flush_in) begin
      // rd/result left as-is: they are don't-care once valid drops
      v_q  <= '0;
      we_q <= '0;
    end else if (!bus.stall_in) begin
      v_q[0]   <= bus.valid_in;
      we_q[0]  <= entry_we_c;
      rd_q[0]  <= bus.rd_sel_in;
      res_q[0] <= bus.alu_result_in;
      for (int k = 1; k < int'(DEPTH); k++) begin
        v_q[k]   <= v_q[k-1];
        we_q[k]  <= we_q[k-1];
        rd_q[k]  <= rd_q[k-1];
        res_q[k] <= res_q[k-1];
      end
    end
  end

  // Last stage drives the write port straight from registers
  assign bus.valid_out        = v_q[LAST];
  assign bus.write_enable_out = v_q[LAST] & we_q[LAST];
  assign bus.rd_sel_out       = rd_q[LAST];
  assign bus.alu_result_out   = res_q[LAST];

`ifdef PIPE_FWD_EN
  // Forwarding lookup: scan oldest to youngest so the lowest matching k wins
  always_comb begin
    bus.fwd_rs1_hit  = 1'b0;
    bus.fwd_rs1_data = '0;
    bus.fwd_rs2_hit  = 1'b0;
    bus.fwd_rs2_data = '0;
    for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
      if (v_q[k] && we_q[k] && (bus.rs1_sel_in != RD_W'(0)) && (rd_q[k] == bus.rs1_sel_in)) begin
        bus.fwd_rs1_hit  = 1'b1;
        bus.fwd_rs1_data = res_q[k];
      end
      if (v_q[k] && we_q[k] && (bus.rs2_sel_in != RD_W'(0)) && (rd_q[k] == bus.rs2_sel_in)) begin
        bus.fwd_rs2_hit  = 1'b1;
        bus.fwd_rs2_data = res_q[k];
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_reg_stage.sv
// tb_pipeline_reg_stage: directed self-checking bench for pipeline_reg_stage
//   at DEPTH=3. Covers reset, latency, x0 squash, stall, flush, reset over
//   stall, and (with PIPE_FWD_EN) the forwarding lookup.
module tb_pipeline_reg_stage;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned RD_W   = 6;
  localparam int unsigned DEPTH  = 3;

  logic clk = 1'b0;
  logic rst;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  pipeline_reg_stage_if #(.DATA_W(DATA_W), .RD_W(RD_W)) bus ();

  pipeline_reg_stage #(.DATA_W(DATA_W), .RD_W(RD_W), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts and reports mismatches
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic we, input logic [RD_W-1:0] rd,
                       input logic [DATA_W-1:0] res);
    bus.valid_in        = v;
    bus.write_enable_in = we;
    bus.rd_sel_in       = rd;
    bus.alu_result_in   = res;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, '0, '0);
  endtask

  task automatic check_out(input string tag, input logic v, input logic we,
                           input logic [RD_W-1:0] rd, input logic [DATA_W-1:0] res);
    check({tag, ".valid"}, 64'(bus.valid_out), 64'(v));
    check({tag, ".we"},    64'(bus.write_enable_out), 64'(we));
    check({tag, ".rd"},    64'(bus.rd_sel_out), 64'(rd));
    check({tag, ".res"},   64'(bus.alu_result_out), 64'(res));
  endtask

  // Stall scenario expectations per edge (e1..e8)
  logic       st_v  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [5:0] st_rd [8] = '{6'd0, 6'd0, 6'd0, 6'd0, 6'd1, 6'd2, 6'd3, 6'd0};
  logic       st_s  [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

  initial begin
    rst         = 1'b1;
    bus.stall_in = 1'b0;
    bus.flush_in = 1'b0;
`ifdef PIPE_FWD_EN
    bus.rs1_sel_in = '0;
    bus.rs2_sel_in = '0;
`endif
    // 1. Reset with live inputs, then idle after release
    drive(1'b1, 1'b1, 6'd9, 32'h5555_AAAA);
    tick();
    tick();
    check_out("reset", 1'b0, 1'b0, '0, '0);
    rst = 1'b0;
    idle();
    for (int i = 0; i < 3; i++) begin
      tick();
      check_out($sformatf("idle%0d", i), 1'b0, 1'b0, '0, '0);
    end

    // 2. Latency: visible exactly after DEPTH edges, for one cycle
    drive(1'b1, 1'b1, 6'd5, 32'hDEAD_BEEF);
    tick();
    idle();
    check("lat.e1.we", 64'(bus.write_enable_out), 64'd0);
    tick();
    check("lat.e2.we", 64'(bus.write_enable_out), 64'd0);
    tick();
    check_out("lat.e3", 1'b1, 1'b1, 6'd5, 32'hDEAD_BEEF);
    tick();
    check("lat.e4.we", 64'(bus.write_enable_out), 64'd0);
    check("lat.e4.valid", 64'(bus.valid_out), 64'd0);

    // 3. x0 squash: valid but no write strobe
    drive(1'b1, 1'b1, 6'd0, 32'h0000_1234);
    tick();
    idle();
    tick();
    tick();
    check_out("x0", 1'b1, 1'b0, 6'd0, 32'h0000_1234);
    tick();

    // 4. Stall for 2 cycles while rd=3 is presented (held upstream)
    for (int e = 0; e < 8; e++) begin
      if (e < 2)      drive(1'b1, 1'b1, 6'(e + 1), 32'(32'h100 + e + 1));
      else if (e < 5) drive(1'b1, 1'b1, 6'd3, 32'h103);
      else            idle();
      bus.stall_in = st_s[e];
      tick();
      check($sformatf("stall.e%0d.valid", e + 1), 64'(bus.valid_out), 64'(st_v[e]));
      check($sformatf("stall.e%0d.we", e + 1), 64'(bus.write_enable_out), 64'(st_v[e]));
      if (st_v[e]) begin
        check($sformatf("stall.e%0d.rd", e + 1), 64'(bus.rd_sel_out), 64'(st_rd[e]));
        check($sformatf("stall.e%0d.res", e + 1), 64'(bus.alu_result_out),
              64'(32'h100 + 32'(st_rd[e])));
      end
    end
    bus.stall_in = 1'b0;

    // 5. Flush with stall on a full pipe; input that cycle is discarded
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, 1'b1, 6'(i), 32'(i));
      tick();
    end
    check_out("fill", 1'b1, 1'b1, 6'd1, 32'd1);
    drive(1'b1, 1'b1, 6'd4, 32'd4);
    bus.flush_in = 1'b1;
    bus.stall_in = 1'b1;
    tick();
    bus.flush_in = 1'b0;
    bus.stall_in = 1'b0;
    idle();
    check("flush.c1.valid", 64'(bus.valid_out), 64'd0);
    check("flush.c1.we", 64'(bus.write_enable_out), 64'd0);
    for (int i = 2; i <= 3; i++) begin
      tick();
      check($sformatf("flush.c%0d.valid", i), 64'(bus.valid_out), 64'd0);
      check($sformatf("flush.c%0d.we", i), 64'(bus.write_enable_out), 64'd0);
    end

    // Reset overrides stall on a full pipe
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, 1'b1, 6'(i + 10), 32'(i + 10));
      tick();
    end
    check("prerst.valid", 64'(bus.valid_out), 64'd1);
    rst = 1'b1;
    bus.stall_in = 1'b1;
    tick();
    check_out("rst_over_stall", 1'b0, 1'b0, '0, '0);
    rst = 1'b0;
    bus.stall_in = 1'b0;
    idle();

`ifdef PIPE_FWD_EN
    // 6. Forwarding: s0 rd7=0xA, s1 rd9=0xC, s2 rd7=0xB
    drive(1'b1, 1'b1, 6'd7, 32'hB);
    tick();
    drive(1'b1, 1'b1, 6'd9, 32'hC);
    tick();
    drive(1'b1, 1'b1, 6'd7, 32'hA);
    tick();
    idle();
    bus.stall_in = 1'b1;
    bus.rs1_sel_in = 6'd7;
    bus.rs2_sel_in = 6'd0;
    #1;
    check("fwd.rs1.hit", 64'(bus.fwd_rs1_hit), 64'd1);
    check("fwd.rs1.data", 64'(bus.fwd_rs1_data), 64'hA);
    check("fwd.rs2.hit_x0", 64'(bus.fwd_rs2_hit), 64'd0);
    check("fwd.rs2.data_x0", 64'(bus.fwd_rs2_data), 64'd0);
    bus.rs1_sel_in = 6'd8;
    bus.rs2_sel_in = 6'd9;
    #1;
    check("fwd.rs1.miss", 64'(bus.fwd_rs1_hit), 64'd0);
    check("fwd.rs1.miss_data", 64'(bus.fwd_rs1_data), 64'd0);
    check("fwd.rs2.hit", 64'(bus.fwd_rs2_hit), 64'd1);
    check("fwd.rs2.data", 64'(bus.fwd_rs2_data), 64'hC);
    bus.stall_in = 1'b0;
    tick();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
